fmap_streamer: RTL and testbench

FMAP_STREAMER -- requirements
Module: fmap_streamer

---
 rtl/fmap_pkg.sv | 18 +
 rtl/fmap_streamer_if.sv | 22 ++
 rtl/fmap_streamer.sv | 123 ++++++++++++
 tb/tb_fmap_streamer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// Shared constants for the feature-map streamer: pixel width default,
// FSM state encoding and an index-width helper.
package fmap_pkg;

  localparam int unsigned PIX_BITS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FIN    = 2'd2
  } state_e;

  // Row/column counter width; a 1x1 map still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/fmap_streamer_if.sv
// Valid/ready pixel stream carrying one pixel with its row/column position.
interface fmap_streamer_if #(
  parameter int unsigned PIX_BITS = 4,
  parameter int unsigned IDX_W    = 6
);
  logic                pix_valid;
  logic                pix_ready;
  logic [PIX_BITS-1:0] pix_data;
  logic [IDX_W-1:0]    pix_row;
  logic [IDX_W-1:0]    pix_col;
  logic                pix_last;

  modport master (
    output pix_valid, pix_data, pix_row, pix_col, pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_data, pix_row, pix_col, pix_last,
    output pix_ready
  );
endinterface

// File: rtl/fmap_streamer.sv
// Captures a completed feature map on the rising edge of fmap_done and
// streams it out pixel by pixel in row-major order over a valid/ready port.
module fmap_streamer
  import fmap_pkg::*;
#(
  parameter int unsigned FMAP_SIZE = 62,
  parameter int unsigned PIX_BITS  = PIX_BITS_DEF,
  parameter int unsigned FMAP_BITS = FMAP_SIZE * FMAP_SIZE * PIX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fmap_done,
  input  logic [FMAP_BITS-1:0] fmap_in,
  fmap_streamer_if.master      pix,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 overrun
);

  localparam int unsigned      IDX_W   = idx_w(FMAP_SIZE);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(FMAP_SIZE - 1);

  state_e               state_q,      state_d;
  logic                 fmap_done_q,  fmap_done_d;
  logic [FMAP_BITS-1:0] fbuf_q,       fbuf_d;
  logic [IDX_W-1:0]     row_q,        row_d;
  logic [IDX_W-1:0]     col_q,        col_d;
  logic                 pix_valid_q,  pix_valid_d;
  logic [PIX_BITS-1:0]  pix_data_q,   pix_data_d;
  logic                 pix_last_q,   pix_last_d;
  logic                 busy_q,       busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q,    overrun_d;

  logic        rise;
  logic [31:0] shamt;

  // Next-state, counters and registered outputs derived from the next state.
  always_comb begin
    state_d     = state_q;
    fbuf_d      = fbuf_q;
    row_d       = row_q;
    col_d       = col_q;
    overrun_d   = overrun_q;
    fmap_done_d = fmap_done;
    rise        = fmap_done & ~fmap_done_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          fbuf_d  = fmap_in;
          row_d   = '0;
          col_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (rise) overrun_d = 1'b1;
        if (pix.pix_ready) begin
          if (pix_last_q) begin
            state_d = ST_FIN;
          end else if (col_q == IDX_MAX) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      ST_FIN: begin
        if (rise) overrun_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pixel mux is driven from next-state values so pix_data lines up with row/col.
    shamt        = (32'(row_d) * FMAP_SIZE + 32'(col_d)) * PIX_BITS;
    pix_data_d   = PIX_BITS'(fbuf_d >> shamt);
    pix_valid_d  = (state_d == ST_STREAM);
    pix_last_d   = pix_valid_d && (row_d == IDX_MAX) && (col_d == IDX_MAX);
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_FIN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fmap_done_q  <= 1'b0;
      fbuf_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      fmap_done_q  <= fmap_done_d;
      fbuf_q       <= fbuf_d;
      row_q        <= row_d;
      col_q        <= col_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_last_q   <= pix_last_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_row   = row_q;
  assign pix.pix_col   = col_q;
  assign pix.pix_last  = pix_last_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_fmap_streamer.sv
// Self-checking bench: 2x2, 1x1 and default 62x62 streamers against a
// row-major pixel-sequence model.
module tb_fmap_streamer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_ov2  = 1'b0;

  // 2x2 instance
  logic        d2_done;
  logic [15:0] d2_in;
  logic        busy2, fd2, ov2;
  fmap_streamer_if #(.PIX_BITS(4), .IDX_W(1)) if2 ();
  fmap_streamer #(.FMAP_SIZE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .fmap_done(d2_done), .fmap_in(d2_in),
    .pix(if2), .busy(busy2), .frame_done(fd2), .overrun(ov2));

  // 1x1 instance
  logic       d1_done;
  logic [3:0] d1_in;
  logic       busy1, fd1, ov1;
  fmap_streamer_if #(.PIX_BITS(4), .IDX_W(1)) if1 ();
  fmap_streamer #(.FMAP_SIZE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .fmap_done(d1_done), .fmap_in(d1_in),
    .pix(if1), .busy(busy1), .frame_done(fd1), .overrun(ov1));

  // Default 62x62 instance
  localparam int unsigned N62 = 62 * 62;
  logic               d62_done;
  logic [N62*4-1:0]   d62_in;
  logic [N62*4-1:0]   img62;
  logic               busy62, fd62, ov62;
  fmap_streamer_if #(.PIX_BITS(4), .IDX_W(6)) if62 ();
  fmap_streamer u62 (
    .clk(clk), .rst_n(rst_n), .fmap_done(d62_done), .fmap_in(d62_in),
    .pix(if62), .busy(busy62), .frame_done(fd62), .overrun(ov62));

  task automatic test_reset();
    logic [10:0] obs;
    @(negedge clk);
    obs = {if2.pix_valid, if2.pix_data, if2.pix_row, if2.pix_col, if2.pix_last, busy2, fd2, ov2};
    n_checks++;
    if (obs !== 11'h0) begin n_fail++; $display("FAIL reset_u2 got=%h exp=%h", obs, 11'h0); end
    obs = {if1.pix_valid, if1.pix_data, if1.pix_row, if1.pix_col, if1.pix_last, busy1, fd1, ov1};
    n_checks++;
    if (obs !== 11'h0) begin n_fail++; $display("FAIL reset_u1 got=%h exp=%h", obs, 11'h0); end
    n_checks++;
    if ({if62.pix_valid, if62.pix_data, if62.pix_row, if62.pix_col, if62.pix_last, busy62, fd62, ov62} !== 22'h0) begin
      n_fail++; $display("FAIL reset_u62 got=%h exp=0", {if62.pix_valid, if62.pix_data, if62.pix_row, if62.pix_col, if62.pix_last, busy62, fd62, ov62});
    end
    rst_n = 1'b1;
  endtask

  // One 2x2 frame; mode 0 ready always, 1 pattern 1,0,0,1, 2 random.
  // inject_at >= 0 raises a second fmap_done edge when that pixel is shown.
  task automatic run_frame2(input logic [15:0] img, input int mode, input int inject_at);
    int n, cyc, busy_cnt;
    bit injected;
    logic rdy;
    logic [3:0] px;
    logic [9:0] obs, exp_v;
    logic [2:0] tail;
    n = 0; cyc = 0; busy_cnt = 0; injected = 0;
    @(negedge clk);
    d2_in = img; d2_done = 1'b1;
    @(negedge clk);
    d2_done = 1'b0;
    while (n < 4 && cyc < 40) begin
      px    = 4'(img >> (n * 4));
      obs   = {if2.pix_valid, if2.pix_data, if2.pix_row, if2.pix_col, if2.pix_last, busy2, fd2};
      exp_v = {1'b1, px, 1'(n / 2), 1'(n % 2), (n == 3), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL frame2_pix%0d cyc%0d got=%h exp=%h", n, cyc, obs, exp_v); end
      busy_cnt += int'(busy2);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (n == inject_at && !injected) begin
        d2_in = ~img; d2_done = 1'b1; injected = 1'b1; exp_ov2 = 1'b1;
      end else begin
        d2_done = 1'b0;
      end
      if2.pix_ready = rdy;
      if (rdy) n++;
      cyc++;
      @(negedge clk);
    end
    d2_done = 1'b0;
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL frame2_timeout got=%0d exp=4", n); end
    tail = {if2.pix_valid, busy2, fd2};
    busy_cnt += int'(busy2);
    n_checks++;
    if (tail !== 3'b011) begin n_fail++; $display("FAIL frame2_fin got=%b exp=011", tail); end
    @(negedge clk);
    tail = {if2.pix_valid, busy2, fd2};
    n_checks++;
    if (tail !== 3'b000) begin n_fail++; $display("FAIL frame2_idle got=%b exp=000", tail); end
    n_checks++;
    if (busy_cnt != cyc + 1) begin n_fail++; $display("FAIL frame2_busy_len got=%0d exp=%0d", busy_cnt, cyc + 1); end
    n_checks++;
    if (ov2 !== exp_ov2) begin n_fail++; $display("FAIL frame2_overrun got=%b exp=%b", ov2, exp_ov2); end
  endtask

  task automatic test_basic();
    run_frame2(16'hDCBA, 0, -1);
  endtask

  task automatic test_ready_toggle();
    run_frame2(16'h5A3C, 1, -1);
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 6; i++) run_frame2(16'($urandom), 2, -1);
  endtask

  task automatic test_overrun();
    run_frame2(16'h1234, 1, 1);
    run_frame2(16'h9876, 0, -1);
    run_frame2(16'hFEC8, 0, 3);
  endtask

  task automatic test_held_done();
    logic [1:0] obs;
    @(negedge clk);
    d2_in = 16'h4321; d2_done = 1'b1; if2.pix_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if2.pix_valid, if2.pix_data} !== 5'h11) begin
      n_fail++; $display("FAIL held_start got=%h exp=11", {if2.pix_valid, if2.pix_data});
    end
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      obs = {if2.pix_valid, busy2};
      n_checks++;
      if (obs !== 2'b00) begin n_fail++; $display("FAIL held_no_restart cyc%0d got=%b exp=00", i, obs); end
      @(negedge clk);
    end
    n_checks++;
    if (ov2 !== exp_ov2) begin n_fail++; $display("FAIL held_overrun got=%b exp=%b", ov2, exp_ov2); end
    d2_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs;
    @(negedge clk);
    d2_in = 16'hA5C3; d2_done = 1'b1; if2.pix_ready = 1'b1;
    @(negedge clk);
    d2_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if2.pix_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_ov2 = 1'b0;
    obs = {if2.pix_valid, if2.pix_data, if2.pix_row, if2.pix_col, if2.pix_last, busy2, fd2, ov2};
    n_checks++;
    if (obs !== 11'h0) begin n_fail++; $display("FAIL reset_mid got=%h exp=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (fd2 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_done got=%b exp=0", fd2); end
    run_frame2(16'h0F1E, 0, -1);
  endtask

  task automatic test_size1();
    logic [9:0] obs;
    @(negedge clk);
    d1_in = 4'h7; d1_done = 1'b1; if1.pix_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      d1_done = 1'b0;
      obs = {if1.pix_valid, if1.pix_data, if1.pix_row, if1.pix_col, if1.pix_last, busy1, fd1};
      n_checks++;
      if (obs !== {1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL size1_pix cyc%0d got=%h exp=%h", i, obs, {1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
      end
    end
    if1.pix_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if1.pix_valid, busy1, fd1} !== 3'b011) begin n_fail++; $display("FAIL size1_fin got=%b exp=011", {if1.pix_valid, busy1, fd1}); end
    @(negedge clk);
    n_checks++;
    if ({if1.pix_valid, busy1, fd1, ov1} !== 4'b0000) begin n_fail++; $display("FAIL size1_idle got=%b exp=0000", {if1.pix_valid, busy1, fd1, ov1}); end
  endtask

  task automatic test_edge_at_reset();
    @(negedge clk);
    rst_n = 1'b0; d1_in = 4'hB; d1_done = 1'b1; if1.pix_ready = 1'b0;
    exp_ov2 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({if1.pix_valid, if1.pix_data, if1.pix_last} !== 6'b1_1011_1) begin
      n_fail++; $display("FAIL reset_release_edge got=%b exp=110111", {if1.pix_valid, if1.pix_data, if1.pix_last});
    end
    if1.pix_ready = 1'b1;
    d1_done = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_release_end got=%b exp=0", busy1); end
  endtask

  task automatic test_full62();
    int n, cyc, wraps;
    logic rdy;
    logic [19:0] obs, exp_v;
    n = 0; cyc = 0; wraps = 0;
    for (int k = 0; k < N62; k++) img62[k*4 +: 4] = 4'($urandom);
    @(negedge clk);
    d62_in = img62; d62_done = 1'b1;
    @(negedge clk);
    d62_done = 1'b0;
    while (n < N62 && cyc < 20000) begin
      obs   = {if62.pix_valid, if62.pix_data, if62.pix_row, if62.pix_col, if62.pix_last, busy62, fd62};
      exp_v = {1'b1, 4'(img62 >> (n * 4)), 6'(n / 62), 6'(n % 62), (n == N62 - 1), 1'b1, 1'b0};
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL full62_pix%0d got=%h exp=%h", n, obs, exp_v); end
      rdy = ($urandom_range(0, 3) != 0);
      if62.pix_ready = rdy;
      if (rdy) begin
        if (n % 62 == 61) wraps++;
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    n_checks++;
    if (n != N62 || wraps != 62) begin n_fail++; $display("FAIL full62_count got=%0d/%0d exp=%0d/62", n, wraps, N62); end
    n_checks++;
    if ({if62.pix_valid, busy62, fd62, if62.pix_row, if62.pix_col} !== {3'b011, 6'd61, 6'd61}) begin
      n_fail++; $display("FAIL full62_fin got=%h exp=%h", {if62.pix_valid, busy62, fd62, if62.pix_row, if62.pix_col}, {3'b011, 6'd61, 6'd61});
    end
    @(negedge clk);
    n_checks++;
    if ({if62.pix_valid, busy62, fd62, ov62} !== 4'b0000) begin n_fail++; $display("FAIL full62_idle got=%b exp=0000", {if62.pix_valid, busy62, fd62, ov62}); end
  endtask

  initial begin
    rst_n = 1'b1;
    d2_done = 1'b0; d2_in = '0; if2.pix_ready = 1'b0;
    d1_done = 1'b0; d1_in = '0; if1.pix_ready = 1'b0;
    d62_done = 1'b0; d62_in = '0; if62.pix_ready = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_basic();
    test_ready_toggle();
    test_random_frames();
    test_overrun();
    test_held_done();
    test_reset_mid();
    test_size1();
    test_edge_at_reset();
    test_full62();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
